// File: rtl/pin_input_conditioner_pkg.sv
// Shared pin-bus definitions for the receive-side pin conditioner.
package pin_input_conditioner_pkg;

   localparam int P1V_NUM_PINS = 32;

   typedef logic [P1V_NUM_PINS-1:0] pin_vec_t;

endpackage

// File: rtl/pin_input_conditioner_glitch_filter.sv
// Single-pin deglitcher: the filtered level follows the synchronized level only
// after it has differed from the current filtered level for FILTER_CYCLES cycles.
module pin_input_conditioner_glitch_filter #(
   parameter int   FILTER_CYCLES = 4,
   parameter logic INIT          = 1'b0
) (
   input  logic clock_80,
   input  logic res,
   input  logic filt_en,
   input  logic sync_lvl,
   output logic flt
);

   localparam int CW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock_80) begin
      if (res) begin
         flt <= INIT;
         cnt <= '0;
      end else if (!filt_en) begin
         // tracking while disabled keeps a later enable free of spurious edges
         flt <= sync_lvl;
         cnt <= '0;
      end else if (sync_lvl == flt) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         flt <= sync_lvl;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pin_input_conditioner.sv
// Pad-to-INA conditioning: synchronizer, optional per-pin deglitch, output
// mirror for driven pins, and registered rise/fall strobes.
module pin_input_conditioner
   import pin_input_conditioner_pkg::*;
#(
   parameter int                   NUM_PINS      = P1V_NUM_PINS,
   parameter int                   SYNC_STAGES   = 2,
   parameter int                   FILTER_CYCLES = 4,
   parameter logic [NUM_PINS-1:0]  INIT          = '0
) (
   input  logic                clock_80,
   input  logic                res,
   input  logic [NUM_PINS-1:0] pin_in,
   input  logic [NUM_PINS-1:0] pin_dir,
   input  logic [NUM_PINS-1:0] pin_out,
   input  logic [NUM_PINS-1:0] filt_en,
   output logic [NUM_PINS-1:0] prop_in,
   output logic [NUM_PINS-1:0] rise,
   output logic [NUM_PINS-1:0] fall
);

   (* ASYNC_REG = "TRUE" *) logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];

   logic [NUM_PINS-1:0] sync_lvl;
   logic [NUM_PINS-1:0] level;
   logic [NUM_PINS-1:0] nxt;

   always_ff @(posedge clock_80) begin
      if (res) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= INIT;
      end else begin
         sync_q[0] <= pin_in;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   generate
      if (FILTER_CYCLES > 0) begin : g_filt
         logic [NUM_PINS-1:0] flt;
         for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
            pin_input_conditioner_glitch_filter #(
               .FILTER_CYCLES (FILTER_CYCLES),
               .INIT          (INIT[i])
            ) u_filter (
               .clock_80 (clock_80),
               .res      (res),
               .filt_en  (filt_en[i]),
               .sync_lvl (sync_lvl[i]),
               .flt      (flt[i])
            );
         end
         assign level = (filt_en & flt) | (~filt_en & sync_lvl);
      end else begin : g_nofilt
         assign level = sync_lvl;
      end
   endgenerate

   assign nxt = (pin_dir & pin_out) | (~pin_dir & level);

   always_ff @(posedge clock_80) begin
      if (res) begin
         prop_in <= INIT;
         rise    <= '0;
         fall    <= '0;
      end else begin
         prop_in <= nxt;
         rise    <= nxt & ~prop_in;
         fall    <= ~nxt & prop_in;
      end
   end

endmodule

// File: tb/tb_pin_input_conditioner.sv
// Directed scenarios plus randomized traffic against a run-length reference model.
module tb_pin_input_conditioner;
   import pin_input_conditioner_pkg::*;

   localparam int F = 4;

   logic     clock_80;
   logic     res;
   pin_vec_t pin_in, pin_dir, pin_out, filt_en;
   pin_vec_t prop_in, rise, fall;

   int n_checks = 0;
   int n_errors = 0;

   pin_input_conditioner #(
      .NUM_PINS      (32),
      .SYNC_STAGES   (2),
      .FILTER_CYCLES (F),
      .INIT          (32'h0)
   ) dut (
      .clock_80 (clock_80),
      .res      (res),
      .pin_in   (pin_in),
      .pin_dir  (pin_dir),
      .pin_out  (pin_out),
      .filt_en  (filt_en),
      .prop_in  (prop_in),
      .rise     (rise),
      .fall     (fall)
   );

   initial clock_80 = 1'b0;
   always #5 clock_80 = ~clock_80;

   // Reference: two-cycle delay line, filtered level flips once the synced
   // level has held a value different from it for F consecutive cycles.
   pin_vec_t m_d0, m_d1, m_flt, m_prop, m_rise, m_fall, m_last;
   int       m_run [32];

   always @(posedge clock_80) begin
      pin_vec_t s, lv, nx;
      if (res) begin
         m_d0 = '0; m_d1 = '0; m_flt = '0; m_prop = '0;
         m_rise = '0; m_fall = '0; m_last = '0;
         for (int i = 0; i < 32; i++) m_run[i] = 0;
      end else begin
         s = m_d1;
         for (int i = 0; i < 32; i++) begin
            if (m_run[i] == 0 || s[i] != m_last[i]) m_run[i] = 1;
            else m_run[i] = m_run[i] + 1;
         end
         m_last = s;
         lv = (filt_en & m_flt) | (~filt_en & s);
         nx = (pin_dir & pin_out) | (~pin_dir & lv);
         m_rise = nx & ~m_prop;
         m_fall = ~nx & m_prop;
         m_prop = nx;
         for (int i = 0; i < 32; i++) begin
            if (!filt_en[i]) m_flt[i] = s[i];
            else if (s[i] != m_flt[i] && m_run[i] >= F) m_flt[i] = s[i];
         end
         m_d1 = m_d0;
         m_d0 = pin_in;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_80);
      @(negedge clock_80);
      chk("model_prop_in", prop_in, m_prop);
      chk("model_rise", rise, m_rise);
      chk("model_fall", fall, m_fall);
   endtask

   initial begin
      pin_vec_t tog;
      res = 1'b1; pin_in = '1; pin_dir = '0; pin_out = '0; filt_en = '0;

      // 1: reset holds zero, release propagates all-ones at edge 3
      repeat (3) tick();
      chk("rst_prop", prop_in, 32'h0);
      chk("rst_rise", rise, 32'h0);
      res = 1'b0;
      tick(); tick();
      chk("rel_e2_prop", prop_in, 32'h0);
      tick();
      chk("rel_e3_prop", prop_in, 32'hFFFF_FFFF);
      chk("rel_e3_rise", rise, 32'hFFFF_FFFF);
      tick();
      chk("rel_e4_rise", rise, 32'h0);

      // 2: unfiltered bit 5
      pin_in = '0;
      repeat (5) tick();
      pin_in[5] = 1'b1;
      tick(); tick();
      chk("p5_e2", 32'(prop_in[5]), 32'h0);
      tick();
      chk("p5_e3", 32'(prop_in[5]), 32'h1);
      chk("r5_e3", 32'(rise[5]), 32'h1);
      tick();
      chk("r5_e4", 32'(rise[5]), 32'h0);
      pin_in[5] = 1'b0;
      repeat (3) tick();
      chk("f5_e3", 32'(fall[5]), 32'h1);
      tick();

      // 3: filtered bit 7, short pulse rejected then long pulse passed
      filt_en[7] = 1'b1;
      repeat (3) tick();
      pin_in[7] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         if (k == 4) pin_in[7] = 1'b0;
         tick();
         chk("p7_short", 32'(prop_in[7] | rise[7]), 32'h0);
      end
      pin_in[7] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         if (k == 5) pin_in[7] = 1'b0;
         tick();
         chk("p7_long", 32'(prop_in[7]), (k >= 7 && k <= 10) ? 32'h1 : 32'h0);
         if (k == 7) chk("r7_long", 32'(rise[7]), 32'h1);
      end
      filt_en[7] = 1'b0;

      // 4: output mirror on bit 30
      pin_dir[30] = 1'b1; pin_out[30] = 1'b1;
      tick();
      chk("p30_dir1", 32'(prop_in[30]), 32'h1);
      chk("r30_dir1", 32'(rise[30]), 32'h1);
      pin_dir[30] = 1'b0;
      tick();
      chk("p30_dir0", 32'(prop_in[30]), 32'h0);
      chk("f30_dir0", 32'(fall[30]), 32'h1);
      pin_out[30] = 1'b0;

      // 5: reset mid-count on filtered bit 3
      filt_en[3] = 1'b1;
      repeat (3) tick();
      pin_in[3] = 1'b1;
      repeat (3) tick();
      res = 1'b1;
      tick();
      chk("p3_rst", 32'(prop_in[3]), 32'h0);
      res = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("p3_after_rst", 32'(prop_in[3]), (k >= 7) ? 32'h1 : 32'h0);
      end
      filt_en[3] = 1'b0;

      // 6: filter enable toggle on a steady pattern
      pin_in = 32'hA5A5_A5A5;
      repeat (6) tick();
      for (int k = 0; k < 12; k++) begin
         filt_en = (k < 6) ? 32'hFFFF_FFFF : 32'h0;
         tick();
         chk("steady_prop", prop_in, 32'hA5A5_A5A5);
         chk("steady_strobe", rise | fall, 32'h0);
      end

      // randomized traffic, model-checked every cycle
      for (int k = 0; k < 800; k++) begin
         tog = $urandom & $urandom & $urandom;
         pin_in = pin_in ^ tog;
         pin_out = pin_out ^ ($urandom & $urandom & $urandom);
         if (k % 60 == 0) begin
            filt_en = $urandom;
            pin_dir = $urandom & $urandom;
         end
         res = ($urandom_range(0, 99) == 0);
         tick();
      end
      res = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
